// File: rtl/crc_pkg.sv
// Shared CRC definitions: FSM state type, generic helper functions and
// presets for the common CRC-16/CRC-32 variants.
package crc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } crc_state_e;

    typedef struct packed {
        logic [5:0]  width;
        logic [31:0] poly;
        logic [31:0] init;
        logic        refin;
        logic        refout;
        logic [31:0] xorout;
        logic [31:0] residue;
    } crc_preset_t;

    localparam crc_preset_t CRC16_XMODEM      = '{6'd16, 32'h0000_1021, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    localparam crc_preset_t CRC16_CCITT_FALSE = '{6'd16, 32'h0000_1021, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    localparam crc_preset_t CRC16_KERMIT      = '{6'd16, 32'h0000_1021, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000};
    localparam crc_preset_t CRC32_ETH         = '{6'd32, 32'h04C1_1DB7, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hC704_DD7B};

    // Fold the low data_w bits of data (MSB first) into the low crc_w bits of crc.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [63:0] data,
                                             input logic [31:0] poly, input int crc_w, input int data_w);
        logic [31:0] c;
        logic [31:0] mask;
        logic        fb;
        mask = (crc_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << crc_w) - 32'h1);
        c    = crc & mask;
        for (int i = 63; i >= 0; i--) begin
            if (i < data_w) begin
                fb = c[crc_w-1] ^ data[i];
                c  = (c << 1) & mask;
                if (fb) c = c ^ (poly & mask);
            end
        end
        return c;
    endfunction

    // Reverse the low w bits of v; upper bits of the result are zero.
    function automatic logic [63:0] bit_rev(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step_comb.sv
// Purely combinational CRC fold of one DATA_W-bit word, MSB first.
module crc_step_comb
    import crc_pkg::*;
#(
    parameter int               DATA_W = 16,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] acc;
    logic             fb;

    // Shift every data bit through the LFSR in a single cycle.
    always_comb begin
        acc = crc_in;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = acc[CRC_W-1] ^ data[i];
            acc = {acc[CRC_W-2:0], 1'b0};
            if (fb) acc = acc ^ POLY;
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker with frame delimiting, one result slot
// and valid/ready handshakes on both the beat input and the result output.
//
// Handshakes: a transfer happens on a clk_in edge where valid & ready are
// both high; valid never waits for ready, and a producer holding valid keeps
// its payload stable until the transfer. in_ready depends only on rst,
// out_valid and out_ready, so the result slot frees and refills in one edge.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int          DATA_W  = 16,
    parameter int          CRC_W   = 16,
    parameter logic [31:0] POLY    = 32'h0000_1021,
    parameter logic [31:0] INIT    = 32'h0000_0000,
    parameter bit          REFIN   = 1'b0,
    parameter bit          REFOUT  = 1'b0,
    parameter logic [31:0] XOROUT  = 32'h0000_0000,
    parameter logic [31:0] RESIDUE = 32'h0000_0000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              chk_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic              out_match,
    output crc_state_e        dbg_state
);

    localparam logic [CRC_W-1:0] POLY_C    = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_C    = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_C  = XOROUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RESIDUE_C = RESIDUE[CRC_W-1:0];

    crc_state_e        state_q;
    logic [CRC_W-1:0]  crc_q;
    logic              chk_q;
    logic [DATA_W-1:0] data_eff;
    logic [CRC_W-1:0]  crc_base;
    logic [CRC_W-1:0]  crc_next;
    logic [CRC_W-1:0]  raw_rev;
    logic [CRC_W-1:0]  crc_final;
    logic              chk_eff;
    logic              accept;

    assign in_ready  = !rst && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state_q;

    // A frame's first beat always starts from INIT and takes chk_mode live.
    assign crc_base = (state_q == IDLE) ? INIT_C : crc_q;
    assign chk_eff  = (state_q == IDLE) ? chk_mode : chk_q;

    // Optional input reflection of the whole word.
    always_comb begin
        data_eff = in_data;
        if (REFIN) begin
            for (int i = 0; i < DATA_W; i++) data_eff[i] = in_data[DATA_W-1-i];
        end
    end

    crc_step_comb #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY_C)
    ) u_step (
        .crc_in  (crc_base),
        .data    (data_eff),
        .crc_out (crc_next)
    );

    // Output reflection and final XOR, applied to the raw register value.
    always_comb begin
        for (int i = 0; i < CRC_W; i++) raw_rev[i] = crc_next[CRC_W-1-i];
        crc_final = (REFOUT ? raw_rev : crc_next) ^ XOROUT_C;
    end

    // Frame FSM, running CRC register and the held result slot.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            crc_q     <= INIT_C;
            chk_q     <= 1'b0;
            out_valid <= 1'b0;
            out_crc   <= '0;
            out_match <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    out_valid <= 1'b1;
                    out_crc   <= crc_final;
                    out_match <= chk_eff && (crc_next == RESIDUE_C);
                    state_q   <= IDLE;
                    crc_q     <= INIT_C;
                end else begin
                    state_q <= RUN;
                    crc_q   <= crc_next;
                    if (state_q == IDLE) chk_q <= chk_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: a 16-bit default instance plus three 8-bit
// instances (XMODEM, CCITT-FALSE, KERMIT) sharing the same handshake inputs.
module tb_crc_stream_engine;
    import crc_pkg::*;

    localparam int NDUT = 4;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        chk_mode;
    logic        out_ready;

    logic        in_ready_a  [NDUT];
    logic        out_valid_a [NDUT];
    logic [15:0] out_crc_a   [NDUT];
    logic        out_match_a [NDUT];
    crc_state_e  dbg_a       [NDUT];

    // Reference parameters per instance.
    int          dw_a     [NDUT] = '{16, 8, 8, 8};
    logic [15:0] init_a   [NDUT] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    bit          refl_a   [NDUT] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] poly_v   = 16'h1021;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ov_cnt   = 0;
    bit          rand_ready = 1'b0;
    logic [15:0] frm_q [$];
    logic [67:0] exp_q [$];
    logic [15:0] held;

    crc_stream_engine u_dut0 (
        .clk_in(clk_in), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
        .in_data(in_data), .in_last(in_last), .chk_mode(chk_mode),
        .out_valid(out_valid_a[0]), .out_ready(out_ready), .out_crc(out_crc_a[0]),
        .out_match(out_match_a[0]), .dbg_state(dbg_a[0])
    );

    crc_stream_engine #(.DATA_W(8), .INIT(32'h0000_0000)) u_dut1 (
        .clk_in(clk_in), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
        .in_data(in_data[7:0]), .in_last(in_last), .chk_mode(chk_mode),
        .out_valid(out_valid_a[1]), .out_ready(out_ready), .out_crc(out_crc_a[1]),
        .out_match(out_match_a[1]), .dbg_state(dbg_a[1])
    );

    crc_stream_engine #(.DATA_W(8), .INIT(32'h0000_FFFF)) u_dut2 (
        .clk_in(clk_in), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[2]),
        .in_data(in_data[7:0]), .in_last(in_last), .chk_mode(chk_mode),
        .out_valid(out_valid_a[2]), .out_ready(out_ready), .out_crc(out_crc_a[2]),
        .out_match(out_match_a[2]), .dbg_state(dbg_a[2])
    );

    crc_stream_engine #(.DATA_W(8), .REFIN(1'b1), .REFOUT(1'b1)) u_dut3 (
        .clk_in(clk_in), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[3]),
        .in_data(in_data[7:0]), .in_last(in_last), .chk_mode(chk_mode),
        .out_valid(out_valid_a[3]), .out_ready(out_ready), .out_crc(out_crc_a[3]),
        .out_match(out_match_a[3]), .dbg_state(dbg_a[3])
    );

    // Clock.
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: remainder of (M * x^16 + INIT * x^len) mod G by long division.
    function automatic logic [15:0] model_raw(input int k);
        bit          bq [$];
        logic [15:0] v;
        logic [15:0] r;
        logic [15:0] ini;
        int          dw;
        int          n;
        dw  = dw_a[k];
        ini = init_a[k];
        foreach (frm_q[b]) begin
            v = frm_q[b];
            for (int j = dw - 1; j >= 0; j--) bq.push_back(refl_a[k] ? v[dw-1-j] : v[j]);
        end
        repeat (16) bq.push_back(1'b0);
        for (int i = 0; i < 16; i++) bq[i] = bq[i] ^ ini[15-i];
        n = bq.size();
        for (int p = 0; p < n - 16; p++) begin
            if (bq[p]) begin
                bq[p] = 1'b0;
                for (int q = 0; q < 16; q++) bq[p+1+q] = bq[p+1+q] ^ poly_v[15-q];
            end
        end
        r = '0;
        for (int q = 0; q < 16; q++) r[15-q] = bq[n-16+q];
        return r;
    endfunction

    function automatic logic [67:0] model_entry(input bit chk);
        logic [67:0] e;
        logic [15:0] raw;
        logic [15:0] fin;
        e = '0;
        for (int k = 0; k < NDUT; k++) begin
            raw = model_raw(k);
            fin = raw;
            if (refl_a[k]) for (int i = 0; i < 16; i++) fin[i] = raw[15-i];
            e[k*17 +: 17] = {chk && (raw == 16'h0000), fin};
        end
        return e;
    endfunction

    // Driver: present one beat and hold it until it is accepted.
    task automatic drive_beat(input logic [15:0] d, input bit last, input bit chk);
        int budget;
        bit done;
        budget   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk_mode = chk;
        while (!done) begin
            @(negedge clk_in);
            if (in_ready_a[0]) done = 1'b1;
            @(posedge clk_in);
            #1;
            budget++;
            if (!done && budget > 500) begin
                check_eq("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
    endtask

    // Driver: queue the expected result for frm_q, then send its beats.
    task automatic send_frame(input bit chk, input int gap_max);
        int n;
        n = frm_q.size();
        exp_q.push_back(model_entry(chk));
        for (int b = 0; b < n; b++) begin
            drive_beat(frm_q[b], b == n - 1, (b == 0) ? chk : 1'($urandom_range(0, 1)));
            if (gap_max > 0 && b < n - 1) begin
                int g;
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    repeat (g) begin @(posedge clk_in); #1; end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare every consumed result against the expected queue.
    always @(negedge clk_in) begin
        if (out_valid_a[0]) ov_cnt++;
        if (!rst && out_valid_a[0] && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [67:0] e;
                e = exp_q.pop_front();
                for (int k = 0; k < NDUT; k++)
                    check_eq($sformatf("dut%0d_result", k), {15'd0, out_match_a[k], out_crc_a[k]}, {15'd0, e[k*17 +: 17]});
            end
        end
    end

    // Random consumer backpressure.
    always @(posedge clk_in) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        chk_mode  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        for (int k = 0; k < NDUT; k++) check_eq($sformatf("rst_in_ready%0d", k), {31'd0, in_ready_a[k]}, 32'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        @(negedge clk_in);
        check_eq("rst_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
        check_eq("rst_out_crc", {16'd0, out_crc_a[0]}, 32'd0);
        check_eq("rst_out_match", {31'd0, out_match_a[0]}, 32'd0);
        check_eq("rst_state", {31'd0, dbg_a[0]}, {31'd0, IDLE});
        check_eq("idle_in_ready", {31'd0, in_ready_a[0]}, 32'd1);
        @(posedge clk_in); #1;

        // Single-beat frames in generate mode.
        frm_q = '{16'h0001};
        send_frame(1'b0, 0);
        @(negedge clk_in);
        check_eq("single_0001_valid", {31'd0, out_valid_a[0]}, 32'd1);
        check_eq("single_0001_crc", {16'd0, out_crc_a[0]}, 32'h1021);
        check_eq("single_0001_match", {31'd0, out_match_a[0]}, 32'd0);
        @(posedge clk_in); #1;
        frm_q = '{16'h0000};
        send_frame(1'b0, 0);
        @(negedge clk_in);
        check_eq("single_0000_crc", {16'd0, out_crc_a[0]}, 32'h0000);
        @(posedge clk_in); #1;

        // Check mode: good and corrupted frame.
        frm_q = '{16'h0001, 16'h1021};
        send_frame(1'b1, 0);
        @(negedge clk_in);
        check_eq("chk_good_crc", {16'd0, out_crc_a[0]}, 32'h0000);
        check_eq("chk_good_match", {31'd0, out_match_a[0]}, 32'd1);
        @(posedge clk_in); #1;
        frm_q = '{16'h0001, 16'h1020};
        send_frame(1'b1, 0);
        @(negedge clk_in);
        check_eq("chk_bad_match", {31'd0, out_match_a[0]}, 32'd0);
        @(posedge clk_in); #1;

        // "123456789" on the 8-bit instances.
        frm_q = '{16'h31, 16'h32, 16'h33, 16'h34, 16'h35, 16'h36, 16'h37, 16'h38, 16'h39};
        send_frame(1'b0, 0);
        @(negedge clk_in);
        check_eq("xmodem_check", {16'd0, out_crc_a[1]}, 32'h31C3);
        check_eq("ccitt_false_check", {16'd0, out_crc_a[2]}, 32'h29B1);
        check_eq("kermit_check", {16'd0, out_crc_a[3]}, 32'h2189);
        @(posedge clk_in); #1;

        // Backpressure with the next frame's beat pending.
        out_ready = 1'b0;
        frm_q = '{16'h0001};
        send_frame(1'b0, 0);
        frm_q = '{16'h0002};
        fork
            send_frame(1'b0, 0);
            begin
                repeat (5) begin
                    @(negedge clk_in);
                    check_eq("bp_in_ready", {31'd0, in_ready_a[0]}, 32'd0);
                    check_eq("bp_out_valid", {31'd0, out_valid_a[0]}, 32'd1);
                    check_eq("bp_out_crc", {16'd0, out_crc_a[0]}, 32'h1021);
                end
                @(posedge clk_in); #1;
                out_ready = 1'b1;
            end
        join
        @(negedge clk_in);
        check_eq("bp_next_valid", {31'd0, out_valid_a[0]}, 32'd1);
        check_eq("bp_next_crc", {16'd0, out_crc_a[0]}, 32'h2042);
        @(posedge clk_in); #1;
        repeat (2) begin @(posedge clk_in); #1; end

        // Back-to-back single-beat frames at full throughput.
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            frm_q = '{16'($urandom)};
            send_frame(1'($urandom_range(0, 1)), 0);
        end
        repeat (3) begin @(posedge clk_in); #1; end
        check_eq("b2b_valid_cycles", ov_cnt, 32'd8);
        check_eq("b2b_all_consumed", exp_q.size(), 32'd0);

        // Reset in the middle of a frame.
        drive_beat(16'h1234, 1'b0, 1'b0);
        drive_beat(16'h5678, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk_in);
        check_eq("mid_frame_state", {31'd0, dbg_a[0]}, {31'd0, RUN});
        @(posedge clk_in); #1;
        rst = 1'b1;
        @(negedge clk_in);
        check_eq("mid_rst_in_ready", {31'd0, in_ready_a[0]}, 32'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        @(negedge clk_in);
        check_eq("mid_rst_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
        check_eq("mid_rst_state", {31'd0, dbg_a[0]}, {31'd0, IDLE});
        @(posedge clk_in); #1;
        frm_q = '{16'h0001};
        send_frame(1'b0, 0);
        @(negedge clk_in);
        check_eq("post_rst_crc", {16'd0, out_crc_a[0]}, 32'h1021);
        @(posedge clk_in); #1;

        // Random frames with gaps and random consumer stalls.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 5);
            frm_q.delete();
            for (int b = 0; b < len; b++) frm_q.push_back(16'($urandom));
            send_frame(1'($urandom_range(0, 1)), 2);
        end
        rand_ready = 1'b0;
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) begin @(posedge clk_in); #1; end
        check_eq("drain_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
